dmem_arbiter: RTL and testbench

// - Shares the single-ported data memory between two requesters: port A (CPU load/store path) and port B (bootloader/debug loader).
// - Sits between the CPU datapath and dmem; serialises accesses with a req/ack handshake.
// - Exports cpu_stall so the CPU holds its PC while its access is pending.

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the data memory.
// slave is the arbiter's view; master is the view of the requesters and memory around it.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_rdata,
      output a_ack, a_rdata, b_ack, b_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_rdata,
      input  a_ack, a_rdata, b_ack, b_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-ported dmem between CPU (A) and loader (B); write ack at t+2, read ack at t+2+MEM_LATENCY.
// Requesters hold req until ack; the losing port simply waits, and cpu_stall holds the CPU meanwhile.
module dmem_arbiter #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int MEM_LATENCY = 1
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus,
   output logic           cpu_stall,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

   state_t            state;
   state_t            state_nxt;
   logic              grant_b;
   logic              last_b;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] a_rdata_q;
   logic [DATA_W-1:0] b_rdata_q;
   logic              any_req;
   logic              pick_b;

   assign any_req = bus.a_req | bus.b_req;
   // On a tie, the port that did not win last time goes next.
   assign pick_b  = bus.b_req & (~bus.a_req | ~last_b);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bus.mem_we  = 1'b0;
      bus.mem_re  = 1'b0;
      bus.a_ack   = 1'b0;
      bus.b_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = ISSUE;
         end
         ISSUE: begin
            bus.mem_we = lat_we;
            bus.mem_re = ~lat_we;
            state_nxt  = lat_we ? DONE : WAIT;
         end
         WAIT: begin
            if (cnt == 4'd1) state_nxt = DONE;
         end
         DONE: begin
            bus.a_ack = ~grant_b;
            bus.b_ack = grant_b;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_b    <= 1'b1;
         grant_b   <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_b   <= pick_b;
                  lat_we    <= pick_b ? bus.b_we    : bus.a_we;
                  lat_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
                  lat_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
               end
            end
            ISSUE: begin
               if (!lat_we) cnt <= CNT_INIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               // Memory data is valid in the last WAIT cycle; land it straight in the port's rdata.
               if (cnt == 4'd1) begin
                  if (grant_b) b_rdata_q <= bus.mem_rdata;
                  else         a_rdata_q <= bus.mem_rdata;
               end
            end
            DONE: begin
               last_b <= grant_b;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
   assign busy          = (state != IDLE);
   assign cpu_stall     = bus.a_req & ~bus.a_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, latency/abort/drop sequences, then random traffic against a transaction model.
module tb_dmem_arbiter;
   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int LAT0 = 1;
   localparam int LAT3 = 3;
   localparam logic [63:0] DEAD = 64'hDEAD;
   localparam logic [63:0] BEEF = 64'hBEEF;
   localparam logic [63:0] JUNK = 64'h0BAD_0BAD_0BAD_0BAD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  r_req, r_we;
   logic [63:0] r_addr [2];
   logic [63:0] r_wdata [2];
   logic        stall0, busy0, stall3, busy3;
   logic [5:0]  ctl0;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

   assign if0.a_req = r_req[0];  assign if3.a_req = r_req[0];
   assign if0.a_we  = r_we[0];   assign if3.a_we  = r_we[0];
   assign if0.a_addr = r_addr[0];   assign if3.a_addr = r_addr[0];
   assign if0.a_wdata = r_wdata[0]; assign if3.a_wdata = r_wdata[0];
   assign if0.b_req = r_req[1];  assign if3.b_req = r_req[1];
   assign if0.b_we  = r_we[1];   assign if3.b_we  = r_we[1];
   assign if0.b_addr = r_addr[1];   assign if3.b_addr = r_addr[1];
   assign if0.b_wdata = r_wdata[1]; assign if3.b_wdata = r_wdata[1];

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT0)) u0 (
      .clk(clk), .reset(reset), .bus(if0.slave), .cpu_stall(stall0), .busy(busy0));
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT3)) u3 (
      .clk(clk), .reset(reset), .bus(if3.slave), .cpu_stall(stall3), .busy(busy3));

   assign ctl0 = {busy0, if0.mem_we, if0.mem_re, if0.a_ack, if0.b_ack, stall0};

   // Memory models: data only valid exactly LAT cycles after the read strobe.
   bit [63:0] mem0 [256];
   bit [63:0] mem3 [256];
   int        age0 = 0, age3 = 0;
   logic [7:0] raddr0 = '0, raddr3 = '0;

   always @(posedge clk) begin
      if (if0.mem_we) mem0[if0.mem_addr[7:0]] <= if0.mem_wdata;
      if (if0.mem_re) begin age0 <= 1; raddr0 <= if0.mem_addr[7:0]; end
      else if (age0 > 0 && age0 < 64) age0 <= age0 + 1;
      if (if3.mem_we) mem3[if3.mem_addr[7:0]] <= if3.mem_wdata;
      if (if3.mem_re) begin age3 <= 1; raddr3 <= if3.mem_addr[7:0]; end
      else if (age3 > 0 && age3 < 64) age3 <= age3 + 1;
   end
   assign if0.mem_rdata = (age0 == LAT0) ? mem0[raddr0] : JUNK;
   assign if3.mem_rdata = (age3 == LAT3) ? mem3[raddr3] : JUNK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [4:0]  in;   // {reset, a_req, a_we, b_req, b_we}
      logic [5:0]  e;    // {busy, mem_we, mem_re, a_ack, b_ack, cpu_stall}
      logic [63:0] ad, ard, brd;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [4:0] in, input logic [5:0] e,
                               input logic [63:0] ad, input logic [63:0] ard, input logic [63:0] brd);
      vec_t v;
      v.name = n; v.in = in; v.e = e; v.ad = ad; v.ard = ard; v.brd = brd;
      return v;
   endfunction

   // Transaction-level reference model for the random phase.
   bit          m_active;
   bit          m_we;
   int          m_port, m_k, m_dur, m_last;
   logic [63:0] m_addr, m_wdata;
   logic [63:0] exp_rd [2];
   bit [63:0]   shadow [256];
   logic [1:0]  ack_e;
   logic [5:0]  e_ctl;
   int re0, re3, ack0, ack3, n0, n3, nwe;
   logic [63:0] rd0, rd3;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      r_req = 2'b00;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      r_req = 2'b00; r_we = 2'b00;
      r_addr[0] = 64'h10; r_wdata[0] = DEAD;
      r_addr[1] = 64'h20; r_wdata[1] = BEEF;
      repeat (2) @(negedge clk);

      vecs.push_back(mk("rst_hold0",  5'b0_11_11, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("rst_hold1",  5'b0_11_11, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("post_rst",   5'b1_00_00, 6'b000000, 0, 0, 0));
      vecs.push_back(mk("tie_idle_a", 5'b1_11_11, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("tie_iss_a",  5'b1_11_11, 6'b110001, 64'h10, 0, 0));
      vecs.push_back(mk("tie_done_a", 5'b1_11_11, 6'b100100, 0, 0, 0));
      vecs.push_back(mk("tie_idle_b", 5'b1_11_11, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("tie_iss_b",  5'b1_11_11, 6'b110001, 64'h20, 0, 0));
      vecs.push_back(mk("tie_done_b", 5'b1_11_11, 6'b100011, 0, 0, 0));
      vecs.push_back(mk("tie_idle_a2",5'b1_11_11, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("tie_iss_a2", 5'b1_11_11, 6'b110001, 64'h10, 0, 0));
      vecs.push_back(mk("tie_done_a2",5'b1_11_11, 6'b100100, 0, 0, 0));
      vecs.push_back(mk("tie_idle_b2",5'b1_11_11, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("tie_iss_b2", 5'b1_11_11, 6'b110001, 64'h20, 0, 0));
      vecs.push_back(mk("tie_done_b2",5'b1_11_11, 6'b100011, 0, 0, 0));
      vecs.push_back(mk("quiet",      5'b1_00_00, 6'b000000, 0, 0, 0));
      vecs.push_back(mk("wr_idle",    5'b1_11_00, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("wr_iss",     5'b1_11_00, 6'b110001, 64'h10, 0, 0));
      vecs.push_back(mk("wr_done",    5'b1_11_00, 6'b100100, 0, 0, 0));
      vecs.push_back(mk("wr_quiet",   5'b1_00_00, 6'b000000, 0, 0, 0));
      vecs.push_back(mk("rd_idle",    5'b1_10_00, 6'b000001, 0, 0, 0));
      vecs.push_back(mk("rd_iss",     5'b1_10_00, 6'b101001, 64'h10, 0, 0));
      vecs.push_back(mk("rd_wait",    5'b1_10_00, 6'b100001, 0, 0, 0));
      vecs.push_back(mk("rd_done",    5'b1_10_00, 6'b100100, 0, DEAD, 0));
      vecs.push_back(mk("rd_quiet",   5'b1_00_00, 6'b000000, 0, DEAD, 0));
      vecs.push_back(mk("brd_idle",   5'b1_00_10, 6'b000000, 0, DEAD, 0));
      vecs.push_back(mk("brd_iss",    5'b1_00_10, 6'b101000, 64'h20, DEAD, 0));
      vecs.push_back(mk("brd_wait",   5'b1_00_10, 6'b100000, 0, DEAD, 0));
      vecs.push_back(mk("brd_done",   5'b1_00_10, 6'b100010, 0, DEAD, BEEF));
      vecs.push_back(mk("brd_quiet",  5'b1_00_00, 6'b000000, 0, DEAD, BEEF));
      vecs.push_back(mk("wr2_idle",   5'b1_11_00, 6'b000001, 0, DEAD, BEEF));
      vecs.push_back(mk("wr2_iss",    5'b1_11_00, 6'b110001, 64'h10, DEAD, BEEF));
      vecs.push_back(mk("wr2_done",   5'b1_11_00, 6'b100100, 0, DEAD, BEEF));

      foreach (vecs[i]) begin
         @(negedge clk);
         {reset, r_req[0], r_we[0], r_req[1], r_we[1]} = vecs[i].in;
         #1;
         chk(vecs[i].name, 64'(ctl0), 64'(vecs[i].e));
         if (vecs[i].e[4] || vecs[i].e[3]) chk({vecs[i].name, "_addr"}, if0.mem_addr, vecs[i].ad);
         chk({vecs[i].name, "_a_rdata"}, if0.a_rdata, vecs[i].ard);
         chk({vecs[i].name, "_b_rdata"}, if0.b_rdata, vecs[i].brd);
      end

      // Read latency on both instances; req dropped after ISSUE must not cancel.
      do_reset();
      re0 = -1; re3 = -1; ack0 = -1; ack3 = -1; n0 = 0; n3 = 0; rd0 = '0; rd3 = '0;
      for (int o = 0; o < 12; o++) begin
         if (o > 0) @(negedge clk);
         if (o == 0) begin r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 64'h10; end
         if (o == 2) r_req[0] = 1'b0;
         #1;
         if (if0.mem_re && re0 < 0) re0 = o;
         if (if3.mem_re && re3 < 0) re3 = o;
         if (if0.a_ack) begin n0++; if (ack0 < 0) ack0 = o; rd0 = if0.a_rdata; end
         if (if3.a_ack) begin n3++; if (ack3 < 0) ack3 = o; rd3 = if3.a_rdata; end
      end
      chk("lat1_mem_re_cycle", 64'(re0), 64'(1));
      chk("lat1_ack_cycle", 64'(ack0), 64'(3));
      chk("lat1_rdata", rd0, DEAD);
      chk("lat1_ack_count", 64'(n0), 64'(1));
      chk("lat3_mem_re_cycle", 64'(re3), 64'(1));
      chk("lat3_ack_cycle", 64'(ack3), 64'(5));
      chk("lat3_rdata", rd3, DEAD);
      chk("lat3_ack_count", 64'(n3), 64'(1));

      // B read to completion on both, then a B read on the latency-3 instance aborted in WAIT.
      ack0 = -1; ack3 = -1;
      for (int o = 0; o < 9; o++) begin
         if (o > 0) @(negedge clk);
         if (o == 0) begin r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 64'h20; end
         if (o == 2) r_req[1] = 1'b0;
         #1;
         if (if0.b_ack && ack0 < 0) ack0 = o;
         if (if3.b_ack && ack3 < 0) ack3 = o;
      end
      chk("b_lat1_ack_cycle", 64'(ack0), 64'(3));
      chk("b_lat3_ack_cycle", 64'(ack3), 64'(5));
      chk("b_lat3_rdata", if3.b_rdata, BEEF);
      n3 = 0;
      for (int o = 0; o < 11; o++) begin
         @(negedge clk);
         if (o == 0) r_req[1] = 1'b1;
         if (o == 1) r_req[1] = 1'b0;
         if (o == 3) reset = 1'b0;
         if (o == 4) reset = 1'b1;
         #1;
         if (if3.b_ack) n3++;
         if (o == 3) chk("abort_pre_busy", 64'(busy3), 64'(1));
         if (o == 4) begin
            chk("abort_ctl", 64'({busy3, if3.mem_re, if3.b_ack}), 64'(0));
            chk("abort_b_rdata", if3.b_rdata, 64'(0));
         end
      end
      chk("abort_no_b_ack", 64'(n3), 64'(0));

      // A write whose req drops during ISSUE still acks exactly once.
      ack0 = -1; n0 = 0; nwe = 0;
      for (int o = 0; o < 10; o++) begin
         @(negedge clk);
         if (o == 0) begin r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 64'h10; r_wdata[0] = DEAD; end
         if (o == 1) r_req[0] = 1'b0;
         #1;
         if (if0.a_ack) begin n0++; if (ack0 < 0) ack0 = o; end
         if (if0.mem_we) nwe++;
      end
      chk("drop_ack_cycle", 64'(ack0), 64'(2));
      chk("drop_ack_count", 64'(n0), 64'(1));
      chk("drop_we_count", 64'(nwe), 64'(1));

      // Random traffic on the latency-1 instance against the transaction model.
      do_reset();
      m_active = 1'b0; m_last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
      m_port = 0; m_k = 0; m_dur = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      for (int c = 0; c < 3000; c++) begin
         ack_e[0] = m_active && m_k == m_dur && m_port == 0;
         ack_e[1] = m_active && m_k == m_dur && m_port == 1;
         e_ctl = {m_active, m_active && m_k == 1 && m_we, m_active && m_k == 1 && !m_we,
                  ack_e[0], ack_e[1], r_req[0] & ~ack_e[0]};
         chk("rnd_ctl", 64'(ctl0), 64'(e_ctl));
         if (m_active && m_k == 1) begin
            chk("rnd_mem_addr", if0.mem_addr, m_addr);
            if (m_we) chk("rnd_mem_wdata", if0.mem_wdata, m_wdata);
         end
         chk("rnd_a_rdata", if0.a_rdata, exp_rd[0]);
         chk("rnd_b_rdata", if0.b_rdata, exp_rd[1]);
         for (int p = 0; p < 2; p++) begin
            if (ack_e[p]) r_req[p] = 1'b0;
            if (!r_req[p] && $urandom_range(0, 2) == 0) begin
               r_req[p]   = 1'b1;
               r_we[p]    = 1'($urandom_range(0, 1));
               r_addr[p]  = {$urandom, $urandom};
               r_addr[p][7:6] = 2'b01;
               r_wdata[p] = {$urandom, $urandom};
            end
         end
         if (m_active) begin
            if (m_k == m_dur) begin
               m_active = 1'b0;
               m_last   = m_port;
            end else begin
               m_k++;
               if (m_k == m_dur && !m_we) exp_rd[m_port] = shadow[m_addr[7:0]];
            end
         end else if (r_req != 2'b00) begin
            m_port   = (r_req == 2'b11) ? 1 - m_last : (r_req[1] ? 1 : 0);
            m_we     = r_we[m_port];
            m_addr   = r_addr[m_port];
            m_wdata  = r_wdata[m_port];
            m_active = 1'b1;
            m_k      = 1;
            m_dur    = m_we ? 2 : 2 + LAT0;
            if (m_we) shadow[m_addr[7:0]] = m_wdata;
         end
         @(negedge clk);
      end
      r_req = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
